// File: rtl/dma_out_burst_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dma_out_burst_wb_if / dma_out_burst_axis_if                              |
// | Wishbone and stream bundles used by the burst stream-to-memory DMA.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dma_out_burst_wb_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic            stb;
   logic            cyc;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   wdat;
   logic [AW-1:0]   adr;
   logic            ack;
   logic [DW-1:0]   rdat;

   modport master (output stb, cyc, we, sel, wdat, adr, input  ack, rdat);
   modport slave  (input  stb, cyc, we, sel, wdat, adr, output ack, rdat);
endinterface

interface dma_out_burst_axis_if #(
   parameter int DW = 32
);
   logic          tvalid;
   logic [DW-1:0] tdata;
   logic          tlast;
   logic          tready;

   modport master (output tvalid, tdata, tlast, input  tready);
   modport slave  (input  tvalid, tdata, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/dma_out_burst.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dma_out_burst                                                            |
// | Buffers a word stream in a FIFO and writes it to memory at base+i*stride.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dma_out_burst #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   dma_out_burst_wb_if.slave   s_wbs,
   dma_out_burst_wb_if.master  m_wbs,
   dma_out_burst_axis_if.slave ss
);

   localparam int              PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  OCC_FULL   = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [7:0]      ADR_CTRL   = 8'h00;
   localparam logic [7:0]      ADR_BASE   = 8'h10;
   localparam logic [7:0]      ADR_LEN    = 8'h20;
   localparam logic [7:0]      ADR_STRIDE = 8'h30;
   localparam logic [7:0]      ADR_COUNT  = 8'h40;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [31:0]         stride_q, stride_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic [LEN_W-1:0]    in_cnt_q, in_cnt_d;
   logic                done_q, done_d;
   logic                last_err_q, last_err_d;
   logic                tlast_seen_q, tlast_seen_d;
   logic                s_ack_q, s_ack_d;
   logic [31:0]         s_dat_q, s_dat_d;
   logic                m_stb_q, m_stb_d;
   logic [DATA_W-1:0]   m_dat_q, m_dat_d;
   logic [ADDR_W-1:0]   m_adr_q, m_adr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      occ_q, occ_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic                w_busy, w_empty, w_full, w_tready;
   logic                w_push, w_pop, w_s_req;
   logic [LEN_W-1:0]    w_in_next;
   logic                w_unused;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      len_d        = len_q;
      stride_d     = stride_q;
      count_d      = count_q;
      in_cnt_d     = in_cnt_q;
      done_d       = done_q;
      last_err_d   = last_err_q;
      tlast_seen_d = tlast_seen_q;
      s_dat_d      = s_dat_q;
      m_stb_d      = m_stb_q;
      m_dat_d      = m_dat_q;
      m_adr_d      = m_adr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;

      w_busy    = (state_q != IDLE);
      w_empty   = (occ_q == '0);
      w_full    = (occ_q == OCC_FULL);
      w_tready  = (state_q == RUN) && !w_full && (in_cnt_q < len_q) && !tlast_seen_q;
      w_push    = ss.tvalid && w_tready;
      w_pop     = m_stb_q && m_wbs.ack;
      w_s_req   = s_wbs.stb && s_wbs.cyc && !s_ack_q;
      w_in_next = in_cnt_q + 1'b1;
      s_ack_d   = w_s_req;

      // Read data is captured before the clear so the first read still sees done.
      if (w_s_req && !s_wbs.we) begin
         case (s_wbs.adr[7:0])
            ADR_CTRL:   s_dat_d = {28'd0, last_err_q, !w_busy, done_q, w_busy};
            ADR_BASE:   s_dat_d = 32'(base_q);
            ADR_LEN:    s_dat_d = 32'(len_q);
            ADR_STRIDE: s_dat_d = stride_q;
            ADR_COUNT:  s_dat_d = 32'(count_q);
            default:    s_dat_d = '0;
         endcase
         if (s_wbs.adr[7:0] == ADR_CTRL) done_d = 1'b0;
      end

      if (w_s_req && s_wbs.we && !w_busy) begin
         case (s_wbs.adr[7:0])
            ADR_CTRL: begin
               if (s_wbs.wdat[0]) begin
                  done_d       = (len_q == '0);
                  count_d      = '0;
                  in_cnt_d     = '0;
                  tlast_seen_d = 1'b0;
                  last_err_d   = 1'b0;
                  if (len_q != '0) state_d = RUN;
               end
            end
            ADR_BASE:   base_d   = ADDR_W'(s_wbs.wdat);
            ADR_LEN:    len_d    = LEN_W'(s_wbs.wdat);
            ADR_STRIDE: stride_d = s_wbs.wdat;
            default:    ;
         endcase
      end

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         in_cnt_d = w_in_next;
         if (ss.tlast && (w_in_next < len_q)) begin
            last_err_d   = 1'b1;
            tlast_seen_d = 1'b1;
            state_d      = FLUSH;
         end else if (w_in_next == len_q) begin
            state_d = FLUSH;
         end
      end

      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_q + 1'b1;
      end

      case ({w_push, w_pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: ;
      endcase

      // An ack always leaves one idle cycle before the next write starts.
      if (w_pop) begin
         m_stb_d = 1'b0;
      end else if (!m_stb_q && !w_empty) begin
         m_stb_d = 1'b1;
         m_dat_d = mem_q[rd_ptr_q];
         m_adr_d = base_q + ADDR_W'(count_q) * ADDR_W'(stride_q);
      end

      if ((state_q == FLUSH) && w_empty && !m_stb_q) begin
         done_d  = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         len_q        <= '0;
         stride_q     <= 32'd4;
         count_q      <= '0;
         in_cnt_q     <= '0;
         done_q       <= 1'b0;
         last_err_q   <= 1'b0;
         tlast_seen_q <= 1'b0;
         s_ack_q      <= 1'b0;
         s_dat_q      <= '0;
         m_stb_q      <= 1'b0;
         m_dat_q      <= '0;
         m_adr_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         len_q        <= len_d;
         stride_q     <= stride_d;
         count_q      <= count_d;
         in_cnt_q     <= in_cnt_d;
         done_q       <= done_d;
         last_err_q   <= last_err_d;
         tlast_seen_q <= tlast_seen_d;
         s_ack_q      <= s_ack_d;
         s_dat_q      <= s_dat_d;
         m_stb_q      <= m_stb_d;
         m_dat_q      <= m_dat_d;
         m_adr_q      <= m_adr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= ss.tdata;
   end

   assign ss.tready  = w_tready;
   assign s_wbs.ack  = s_ack_q;
   assign s_wbs.rdat = s_dat_q;
   assign m_wbs.stb  = m_stb_q;
   assign m_wbs.cyc  = m_stb_q;
   assign m_wbs.we   = m_stb_q;
   assign m_wbs.sel  = {(DATA_W/8){m_stb_q}};
   assign m_wbs.wdat = m_dat_q;
   assign m_wbs.adr  = m_adr_q;
   assign w_unused   = ^{s_wbs.sel, s_wbs.adr[31:8], m_wbs.rdat};

endmodule
`default_nettype wire

// File: doc/dma_out_burst.md
Name: dma_out_burst

Overview:
Parametrised successor to the single-word stream-to-memory DMA. It accepts words on an AXI-stream-like slave port and buffers them in an internal FIFO. It writes each word to SDRAM over a Wishbone master at base + index*stride. A Wishbone slave register file configures it and adds status reporting: done/idle flags, a transferred-word count and early-tlast error detection. It sits between a user streaming kernel and the SDRAM Wishbone arbiter.

Parameters:
DATA_W, 32, stream and Wishbone data width (multiple of 8)
ADDR_W, 32, Wishbone address width
FIFO_DEPTH, 8, buffer entries (power of 2, >=2)
LEN_W, 16, width of the length and count registers

Ports:
clk  in  1  system clock
rst  in  1  reset, active-low, asynchronous assert; deassertion is synchronised to clk by the integrator
s_wbs_stb_i  in  1  slave strobe
s_wbs_cyc_i  in  1  slave cycle
s_wbs_we_i  in  1  slave write enable
s_wbs_sel_i  in  4  byte selects (ignored; full-word access)
s_wbs_dat_i  in  32  slave write data
s_wbs_adr_i  in  32  slave address; decoded on bits [7:0]
s_wbs_ack_o  out  1  slave ack
s_wbs_dat_o  out  32  slave read data
m_wbs_stb_o  out  1  master strobe
m_wbs_cyc_o  out  1  master cycle
m_wbs_we_o  out  1  master write enable (always 1 when cyc)
m_wbs_sel_o  out  DATA_W/8  byte selects (all ones when cyc)
m_wbs_dat_o  out  DATA_W  write data
m_wbs_adr_o  out  ADDR_W  write address
m_wbs_ack_i  in  1  master ack
m_wbs_dat_i  in  DATA_W  unused
ss_tvalid  in  1  stream valid
ss_tdata  in  DATA_W  stream data
ss_tlast  in  1  stream last
ss_tready  out  1  stream ready

Behaviour:
- Reset (rst=0): all outputs 0 immediately.
  - FIFO flushed; counters cleared.
  - Registers: base=0, length=0, stride=4.
  - ap_idle=1, ap_done=0, last_err=0.
  - An in-flight master cycle is abandoned.
- Register map (slave):
  - 0x00 AP_CTRL: bit0 ap_start (W1 starts; reads 1 while busy), bit1 ap_done (sticky; cleared by read of 0x00 or by new start), bit2 ap_idle, bit3 last_err.
  - 0x10 base address.
  - 0x20 length in words.
  - 0x30 stride in bytes.
  - 0x40 count (RO, words written to memory).
  - Unmapped addresses read 0; writes to them are ignored.
- Slave handshake:
  - s_wbs_ack_o pulses for 1 cycle, the cycle after stb&cyc is seen with ack low.
  - Read data is valid with ack.
  - Writes to 0x10/0x20/0x30 and ap_start while busy are acked but ignored.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE→RUN on ap_start write with length!=0.
  - ap_start write with length==0: stay IDLE, set ap_done the next cycle, no bus traffic.
  - RUN: ss_tready = !fifo_full && in_cnt<length && !tlast_seen. A push occurs on tvalid&tready; in_cnt increments.
  - ss_tlast accepted with in_cnt+1<length: set last_err, set tlast_seen, go to FLUSH.
  - tlast absent on the final word: no error; the transfer ends at length.
  - RUN→FLUSH when in_cnt reaches length.
  - FLUSH: tready=0; the FIFO drains. When empty and no cycle is active: set ap_done, go to IDLE.
- Master handshake:
  - Starts a cycle whenever the FIFO is non-empty and no cycle is active.
  - stb=cyc=we=1; dat=FIFO head; adr=base+count*stride (modulo 2^ADDR_W).
  - All master outputs are held stable until m_wbs_ack_i.
  - On ack: pop, increment count, drop stb/cyc for 1 cycle, then start the next cycle if data is available.
  - m_wbs_ack_i is ignored when stb=0.
- Latency: a word accepted at edge k drives m_wbs_stb_o high from edge k+1 at the earliest.
- FIFO:
  - Full: tready=0 even if a pop occurs in the same cycle; no push-through when full.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Empty: master stays idle.
- Counter and address widths:
  - count is LEN_W bits.
  - The address product is truncated to ADDR_W bits.

Test Plan:
- Basic transfer: base=8, length=50, stride=4; data 0..49 with random 0-4 cycle gaps on both stream and ack. Required: 50 writes, word i at address 8+4i with data i; ap_done=1; count=50; last_err=0.
- Backpressure: master ack withheld for 30 cycles with the stream continuously valid. Required: tready drops after exactly FIFO_DEPTH accepts; after ack resumes, all data arrives in order with no loss or duplication.
- Early tlast: length=50, tlast on word 20. Required: 20 writes; then ap_done=1, last_err=1, count=20; tready stays 0 afterwards.
- Zero length and wrap: a start with length=0 gives ap_done next cycle and no master stb. Then base=0xFFFF_FFF8, stride=4, length=4 gives addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Busy protection and clear-on-read:
  - A write of base=0x100 mid-transfer is ignored; addresses continue from the original base.
  - The first read of 0x00 after completion returns done=1; the second returns done=0, idle=1.
- Reset mid-transfer: assert rst low during an active master cycle. Required: stb/cyc/tready/ack drop within the same cycle (asynchronous); a fresh 10-word transfer after release completes correctly from count=0.
